// File: rtl/risc_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory handshake.
// Optional memory-wait watchdog is enabled by defining MEM_TIMEOUT_EN.
module risc_multicycle_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_en,
    output logic             reg_we,
    output logic             wb_sel,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_STORE  = 4'b1001;
    localparam logic [3:0] OP_BRANCH = 4'b1010;
    localparam logic [3:0] OP_JUMP   = 4'b1011;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'b0001) && (op <= 4'b0111);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'b1100) && (op <= 4'b1110);
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic             w_timeout;
    logic [CNT_W-1:0] r_retired;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] r_wait;
    logic       w_waiting;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = w_waiting && (r_wait == 4'(TIMEOUT - 1));

    // Wait counter: counts consecutive stalled edges, cleared by any non-wait edge
    always_ff @(negedge CLK or negedge R) begin
        if (!R) begin
            r_wait <= 4'd0;
        end else if (w_waiting) begin
            r_wait <= r_wait + 4'd1;
        end else begin
            r_wait <= 4'd0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout        = 1'b0;
`endif

    // Next-state, retire and strobe decode
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
                else       w_next = S_IDLE;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    w_next   = S_HALTED;
                    w_retire = 1'b1;
                end else if (is_illegal(opcode)) begin
                    w_next = S_ERROR;
                end else if (opcode == OP_NOP) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu(opcode)) begin
                    alu_en = 1'b1;
                    w_next = S_WB;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    alu_en = 1'b1;
                    w_next = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    pc_we    = zero;
                    pc_src   = zero;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (opcode == OP_JUMP) begin
                    pc_we    = 1'b1;
                    pc_src   = 1'b1;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    // opcode changed after DECODE: treat as a fault
                    w_next = S_ERROR;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                wb_sel   = (opcode == OP_LOAD);
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALTED: begin
                if (start) w_next = S_FETCH;
                else       w_next = S_HALTED;
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    // State and retired-count registers, falling-edge with async reset
    always_ff @(negedge CLK or negedge R) begin
        if (!R) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end else begin
                r_retired <= r_retired;
            end
        end
    end

    assign state   = r_state;
    assign retired = r_retired;
    assign busy    = (r_state != S_IDLE) && (r_state != S_HALTED) && (r_state != S_ERROR);
    assign halted  = (r_state == S_HALTED);
    assign error   = (r_state == S_ERROR);

endmodule

// File: tb/tb_risc_multicycle_sequencer.sv
// Directed bench for risc_multicycle_sequencer: expected post-edge state and
// retired count are queued when inputs are driven and checked after the edge.
module tb_risc_multicycle_sequencer;

    logic        CLK;
    logic        R;
    logic        start;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, ir_we, pc_we, pc_src, alu_en, reg_we, wb_sel;
    logic [2:0]  state;
    logic        busy, halted, error;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] ret;
    } exp_t;

    exp_t sb[$];

    risc_multicycle_sequencer #(.CNT_W(16), .TIMEOUT(15)) dut (
        .CLK(CLK), .R(R), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_en(alu_en),
        .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .busy(busy),
        .halted(halted), .error(error), .retired(retired)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic [3:0] op, input logic z, input logic rdy);
        start     = s;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic edge_chk(input string tag, input logic [2:0] nst, input logic [15:0] nret);
        exp_t e;
        sb.push_back('{tag, nst, nret});
        @(negedge CLK);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_state"}, {29'd0, state}, {29'd0, e.st});
        chk({e.tag, "_retired"}, {16'd0, retired}, {16'd0, e.ret});
    endtask

    task automatic fetch_ok(input string tag, input logic [3:0] op, input logic [15:0] ret);
        set_in(1'b0, op, 1'b0, 1'b1);
        chk({tag, "_f_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_f_ir_we"}, {31'd0, ir_we}, 32'd1);
        chk({tag, "_f_pc_we"}, {31'd0, pc_we}, 32'd1);
        chk({tag, "_f_pc_src"}, {31'd0, pc_src}, 32'd0);
        edge_chk({tag, "_to_decode"}, 3'd2, ret);
    endtask

    initial begin
        R = 1'b0;
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_strobes", {24'd0, mem_req, mem_we, ir_we, pc_we, pc_src, alu_en, reg_we, wb_sel}, 32'd0);
        chk("rst_flags", {29'd0, busy, halted, error}, 32'd0);
        #11 R = 1'b1;
        @(negedge CLK);
        #1;
        set_in(1'b0, 4'd0, 1'b0, 1'b1);
        edge_chk("idle_hold", 3'd0, 16'd0);
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        edge_chk("idle_start", 3'd1, 16'd0);

        // NOP, with start and mem_ready asserted in DECODE (both ignored)
        fetch_ok("nop", 4'd0, 16'd0);
        set_in(1'b1, 4'd0, 1'b0, 1'b1);
        chk("nop_d_ir_we", {31'd0, ir_we}, 32'd0);
        chk("nop_d_pc_we", {31'd0, pc_we}, 32'd0);
        chk("nop_d_busy", {31'd0, busy}, 32'd1);
        chk("nop_d_mem_req", {31'd0, mem_req}, 32'd0);
        edge_chk("nop_retire", 3'd1, 16'd1);

        // LOAD with three MEM wait cycles
        fetch_ok("ld", 4'd8, 16'd1);
        set_in(1'b0, 4'd8, 1'b0, 1'b0);
        edge_chk("ld_to_exec", 3'd3, 16'd1);
        set_in(1'b0, 4'd8, 1'b0, 1'b1);
        chk("ld_e_alu_en", {31'd0, alu_en}, 32'd1);
        chk("ld_e_pc_we", {31'd0, pc_we}, 32'd0);
        chk("ld_e_mem_req", {31'd0, mem_req}, 32'd0);
        edge_chk("ld_to_mem", 3'd4, 16'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 4'd8, 1'b0, 1'b0);
            chk("ld_m_mem_req", {31'd0, mem_req}, 32'd1);
            chk("ld_m_mem_we", {31'd0, mem_we}, 32'd0);
            edge_chk("ld_m_wait", 3'd4, 16'd1);
        end
        set_in(1'b0, 4'd8, 1'b0, 1'b1);
        edge_chk("ld_to_wb", 3'd5, 16'd1);
        set_in(1'b0, 4'd8, 1'b0, 1'b0);
        chk("ld_wb_reg_we", {31'd0, reg_we}, 32'd1);
        chk("ld_wb_wb_sel", {31'd0, wb_sel}, 32'd1);
        chk("ld_wb_alu_en", {31'd0, alu_en}, 32'd0);
        edge_chk("ld_retire", 3'd1, 16'd2);

        // STORE, zero wait
        fetch_ok("st", 4'd9, 16'd2);
        set_in(1'b0, 4'd9, 1'b0, 1'b0);
        edge_chk("st_to_exec", 3'd3, 16'd2);
        set_in(1'b0, 4'd9, 1'b0, 1'b0);
        chk("st_e_alu_en", {31'd0, alu_en}, 32'd1);
        edge_chk("st_to_mem", 3'd4, 16'd2);
        set_in(1'b0, 4'd9, 1'b0, 1'b1);
        chk("st_m_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_m_mem_req", {31'd0, mem_req}, 32'd1);
        edge_chk("st_retire", 3'd1, 16'd3);

        // ALU reg-reg
        fetch_ok("alu", 4'd5, 16'd3);
        set_in(1'b0, 4'd5, 1'b0, 1'b0);
        edge_chk("alu_to_exec", 3'd3, 16'd3);
        set_in(1'b0, 4'd5, 1'b0, 1'b0);
        chk("alu_e_alu_en", {31'd0, alu_en}, 32'd1);
        edge_chk("alu_to_wb", 3'd5, 16'd3);
        set_in(1'b0, 4'd5, 1'b0, 1'b1);
        chk("alu_wb_reg_we", {31'd0, reg_we}, 32'd1);
        chk("alu_wb_wb_sel", {31'd0, wb_sel}, 32'd0);
        edge_chk("alu_retire", 3'd1, 16'd4);

        // BRANCH not taken, then taken
        fetch_ok("bnt", 4'd10, 16'd4);
        set_in(1'b0, 4'd10, 1'b0, 1'b0);
        edge_chk("bnt_to_exec", 3'd3, 16'd4);
        set_in(1'b0, 4'd10, 1'b0, 1'b1);
        chk("bnt_pc_we", {31'd0, pc_we}, 32'd0);
        chk("bnt_pc_src", {31'd0, pc_src}, 32'd0);
        edge_chk("bnt_retire", 3'd1, 16'd5);
        fetch_ok("bt", 4'd10, 16'd5);
        set_in(1'b0, 4'd10, 1'b1, 1'b0);
        edge_chk("bt_to_exec", 3'd3, 16'd5);
        set_in(1'b0, 4'd10, 1'b1, 1'b0);
        chk("bt_pc_we", {31'd0, pc_we}, 32'd1);
        chk("bt_pc_src", {31'd0, pc_src}, 32'd1);
        edge_chk("bt_retire", 3'd1, 16'd6);

        // JUMP with one FETCH wait cycle
        set_in(1'b0, 4'd11, 1'b0, 1'b0);
        chk("jmp_fw_ir_we", {31'd0, ir_we}, 32'd0);
        chk("jmp_fw_pc_we", {31'd0, pc_we}, 32'd0);
        chk("jmp_fw_mem_req", {31'd0, mem_req}, 32'd1);
        edge_chk("jmp_fetch_wait", 3'd1, 16'd6);
        fetch_ok("jmp", 4'd11, 16'd6);
        set_in(1'b0, 4'd11, 1'b0, 1'b0);
        edge_chk("jmp_to_exec", 3'd3, 16'd6);
        set_in(1'b0, 4'd11, 1'b0, 1'b0);
        chk("jmp_pc_we", {31'd0, pc_we}, 32'd1);
        chk("jmp_pc_src", {31'd0, pc_src}, 32'd1);
        edge_chk("jmp_retire", 3'd1, 16'd7);

        // HALT retires on entry, resumes on start
        fetch_ok("halt", 4'd15, 16'd7);
        set_in(1'b0, 4'd15, 1'b0, 1'b0);
        edge_chk("halt_enter", 3'd6, 16'd8);
        chk("halt_flags", {29'd0, busy, halted, error}, 32'b010);
        set_in(1'b0, 4'd15, 1'b0, 1'b1);
        edge_chk("halt_hold", 3'd6, 16'd8);
        set_in(1'b1, 4'd15, 1'b0, 1'b0);
        edge_chk("halt_resume", 3'd1, 16'd8);

        // Illegal opcode: sticky ERROR
        fetch_ok("ill", 4'd12, 16'd8);
        set_in(1'b0, 4'd12, 1'b0, 1'b0);
        edge_chk("ill_to_error", 3'd7, 16'd8);
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 4'd12, 1'b1, 1'b1);
            chk("err_flags", {29'd0, busy, halted, error}, 32'b001);
            chk("err_strobes", {24'd0, mem_req, mem_we, ir_we, pc_we, pc_src, alu_en, reg_we, wb_sel}, 32'd0);
            edge_chk("err_sticky", 3'd7, 16'd8);
        end
        R = 1'b0;
        #1;
        chk("err_rst_state", {29'd0, state}, 32'd0);
        chk("err_rst_retired", {16'd0, retired}, 32'd0);
        chk("err_rst_error", {31'd0, error}, 32'd0);
        #3 R = 1'b1;
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        edge_chk("err_rst_idle", 3'd0, 16'd0);

        // Reset mid-MEM handshake
        set_in(1'b1, 4'd8, 1'b0, 1'b0);
        edge_chk("mr_start", 3'd1, 16'd0);
        fetch_ok("mr", 4'd8, 16'd0);
        set_in(1'b0, 4'd8, 1'b0, 1'b0);
        edge_chk("mr_to_exec", 3'd3, 16'd0);
        set_in(1'b0, 4'd8, 1'b0, 1'b0);
        edge_chk("mr_to_mem", 3'd4, 16'd0);
        set_in(1'b0, 4'd8, 1'b0, 1'b0);
        chk("mr_mem_req_on", {31'd0, mem_req}, 32'd1);
        R = 1'b0;
        #1;
        chk("mr_mem_req_off", {31'd0, mem_req}, 32'd0);
        chk("mr_state", {29'd0, state}, 32'd0);
        #3 R = 1'b1;
        set_in(1'b0, 4'd8, 1'b0, 1'b0);
        edge_chk("mr_idle", 3'd0, 16'd0);

`ifdef MEM_TIMEOUT_EN
        // FETCH watchdog: 15th wait edge -> ERROR
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        edge_chk("to_start", 3'd1, 16'd0);
        for (int i = 0; i < 14; i++) begin
            set_in(1'b0, 4'd0, 1'b0, 1'b0);
            edge_chk("to_wait", 3'd1, 16'd0);
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        edge_chk("to_expire", 3'd7, 16'd0);
        chk("to_mem_req", {31'd0, mem_req}, 32'd0);
        R = 1'b0;
        #4 R = 1'b1;
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        edge_chk("to2_start", 3'd1, 16'd0);
        for (int i = 0; i < 14; i++) begin
            set_in(1'b0, 4'd0, 1'b0, 1'b0);
            edge_chk("to2_wait", 3'd1, 16'd0);
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b1);
        edge_chk("to2_ready_wins", 3'd2, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
